mem_ctrler: RTL and testbench

- Responder for the load/store buffer's two memory request ports: the cache-line port and the IO byte port.
- Serialises every accepted request onto the byte-wide RAM/IO bus, one byte per cycle.
- Returns a one-cycle ready pulse, plus the read data for loads.
- Sits between ls_buffer and the top-level memory/hci pins.

---
 rtl/mem_ctrler.sv | 176 +++++++++++++++++
 tb/tb_mem_ctrler.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrler.sv
// Byte-serial memory controller answering the load/store buffer's cache-line
// port and IO byte port over a shared byte-wide RAM/IO bus.
module mem_ctrler #(
    parameter int LINE_BYTES = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,

    input  logic                    valid_from_ls_buffer,
    input  logic                    rw_flag_from_ls_buffer,
    input  logic [ADDR_WIDTH-1:0]   addr_from_ls_buffer,
    input  logic [LINE_BYTES*8-1:0] cache_line_from_ls_buffer,
    output logic                    ready_to_ls_buffer,
    output logic [LINE_BYTES*8-1:0] cache_line_to_ls_buffer,

    input  logic                    valid_from_ls_buffer_io,
    input  logic                    rw_flag_from_ls_buffer_io,
    input  logic [ADDR_WIDTH-1:0]   addr_from_ls_buffer_io,
    input  logic [7:0]              byte_from_ls_buffer_io,
    output logic                    ready_to_ls_buffer_io,
    output logic [7:0]              byte_to_ls_buffer_io,

    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [ADDR_WIDTH-1:0]   mem_a,
    output logic                    mem_wr,
    input  logic                    io_buffer_full
);

    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int CNT_W  = $clog2(LINE_BYTES + 3);
    localparam int LINE_W = LINE_BYTES * 8;

    typedef enum logic [2:0] {
        IDLE,
        LINE_READ,
        LINE_WRITE,
        IO_READ,
        IO_WRITE
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_W-1:0]     line_q;
    logic [7:0]            byte_q;
    logic [ADDR_WIDTH-1:0] mem_a_q;
    logic [7:0]            mem_dout_q;
    logic                  mem_wr_q;

    logic [ADDR_WIDTH-1:0] line_base;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [OFF_W-1:0]      rd_idx;
    logic [OFF_W-1:0]      wr_idx;
    logic                  io_wr_now;
    logic                  can_accept;

    assign line_base  = addr_from_ls_buffer & ~ADDR_WIDTH'(LINE_BYTES - 1);
    assign next_addr  = addr_q + ADDR_WIDTH'(cnt) + ADDR_WIDTH'(1);
    assign rd_idx     = OFF_W'(cnt - CNT_W'(1));
    assign wr_idx     = OFF_W'(cnt + CNT_W'(1));
    assign can_accept = !ready_to_ls_buffer && !ready_to_ls_buffer_io;

    // The IO write beat follows io_buffer_full in the same cycle, so it bypasses
    // the bus registers; everything else on the bus is registered.
    assign io_wr_now = (state == IO_WRITE) && !io_buffer_full;

    always_comb begin
        mem_a    = mem_a_q;
        mem_dout = mem_dout_q;
        if (io_wr_now) begin
            mem_a    = addr_q;
            mem_dout = byte_q;
        end
        mem_wr = rdy && (io_wr_now || mem_wr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                   <= IDLE;
            cnt                     <= '0;
            addr_q                  <= '0;
            line_q                  <= '0;
            byte_q                  <= '0;
            mem_a_q                 <= '0;
            mem_dout_q              <= '0;
            mem_wr_q                <= 1'b0;
            ready_to_ls_buffer      <= 1'b0;
            ready_to_ls_buffer_io   <= 1'b0;
            cache_line_to_ls_buffer <= '0;
            byte_to_ls_buffer_io    <= '0;
        end else if (rdy) begin
            ready_to_ls_buffer    <= 1'b0;
            ready_to_ls_buffer_io <= 1'b0;
            case (state)
                IDLE: begin
                    // A ready cycle blocks acceptance so the client can re-present
                    // a fresh request with valid still held high.
                    if (can_accept && valid_from_ls_buffer) begin
                        cnt     <= '0;
                        addr_q  <= line_base;
                        line_q  <= cache_line_from_ls_buffer;
                        mem_a_q <= line_base;
                        if (rw_flag_from_ls_buffer) begin
                            state      <= LINE_WRITE;
                            mem_wr_q   <= 1'b1;
                            mem_dout_q <= cache_line_from_ls_buffer[7:0];
                        end else begin
                            state <= LINE_READ;
                        end
                    end else if (can_accept && valid_from_ls_buffer_io) begin
                        cnt    <= '0;
                        addr_q <= addr_from_ls_buffer_io;
                        byte_q <= byte_from_ls_buffer_io;
                        if (rw_flag_from_ls_buffer_io) begin
                            state <= IO_WRITE;
                        end else begin
                            state   <= IO_READ;
                            mem_a_q <= addr_from_ls_buffer_io;
                        end
                    end
                end
                LINE_READ: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt < CNT_W'(LINE_BYTES - 1)) begin
                        mem_a_q <= next_addr;
                    end else begin
                        mem_a_q <= '0;
                    end
                    // mem_din lags the address by one cycle.
                    if (cnt != '0) begin
                        cache_line_to_ls_buffer[{rd_idx, 3'b000} +: 8] <= mem_din;
                    end
                    if (cnt == CNT_W'(LINE_BYTES)) begin
                        ready_to_ls_buffer <= 1'b1;
                        state              <= IDLE;
                    end
                end
                LINE_WRITE: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt < CNT_W'(LINE_BYTES - 1)) begin
                        mem_a_q    <= next_addr;
                        mem_dout_q <= line_q[{wr_idx, 3'b000} +: 8];
                    end else begin
                        mem_a_q            <= '0;
                        mem_dout_q         <= '0;
                        mem_wr_q           <= 1'b0;
                        ready_to_ls_buffer <= 1'b1;
                        state              <= IDLE;
                    end
                end
                IO_READ: begin
                    cnt <= cnt + CNT_W'(1);
                    // IO reads have side effects: the address is on the bus once only.
                    if (cnt == '0) begin
                        mem_a_q <= '0;
                    end else begin
                        byte_to_ls_buffer_io  <= mem_din;
                        ready_to_ls_buffer_io <= 1'b1;
                        state                 <= IDLE;
                    end
                end
                IO_WRITE: begin
                    if (!io_buffer_full) begin
                        ready_to_ls_buffer_io <= 1'b1;
                        state                 <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrler.sv
// Randomised bench for mem_ctrler: bus traces checked per operation against a
// cycle table built from the transfer rules, responses checked by a scoreboard.
module tb_mem_ctrler;

    localparam int LB = 16;
    localparam int AW = 32;
    localparam int W  = LB * 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rdy;
    logic          valid_line, rw_line;
    logic [AW-1:0] addr_line;
    logic [W-1:0]  line_in;
    logic          ready_line;
    logic [W-1:0]  line_out;
    logic          valid_io, rw_io;
    logic [AW-1:0] addr_io;
    logic [7:0]    byte_in;
    logic          ready_io;
    logic [7:0]    byte_out;
    logic [7:0]    mem_din = 8'h00;
    logic [7:0]    mem_dout;
    logic [AW-1:0] mem_a;
    logic          mem_wr;
    logic          io_buffer_full;

    always #5 clk = ~clk;

    mem_ctrler #(.LINE_BYTES(LB), .ADDR_WIDTH(AW)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .rdy                       (rdy),
        .valid_from_ls_buffer      (valid_line),
        .rw_flag_from_ls_buffer    (rw_line),
        .addr_from_ls_buffer       (addr_line),
        .cache_line_from_ls_buffer (line_in),
        .ready_to_ls_buffer        (ready_line),
        .cache_line_to_ls_buffer   (line_out),
        .valid_from_ls_buffer_io   (valid_io),
        .rw_flag_from_ls_buffer_io (rw_io),
        .addr_from_ls_buffer_io    (addr_io),
        .byte_from_ls_buffer_io    (byte_in),
        .ready_to_ls_buffer_io     (ready_io),
        .byte_to_ls_buffer_io      (byte_out),
        .mem_din                   (mem_din),
        .mem_dout                  (mem_dout),
        .mem_a                     (mem_a),
        .mem_wr                    (mem_wr),
        .io_buffer_full            (io_buffer_full)
    );

    logic [7:0]   ram     [int unsigned];
    logic [7:0]   ref_mem [int unsigned];
    logic [W-1:0] exp_q    [$];
    logic [7:0]   exp_io_q [$];
    logic [W-1:0] last_line = '0;
    logic [7:0]   last_byte = '0;
    int           n_vec = 0;
    int           n_err = 0;
    logic         prev_any = 1'b0;

    function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5C;
    endfunction

    function automatic logic [7:0] env_rd(input logic [AW-1:0] a);
        int unsigned k;
        k = a;
        return ram.exists(k) ? ram[k] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
        int unsigned k;
        k = a;
        return ref_mem.exists(k) ? ref_mem[k] : init_byte(a);
    endfunction

    // Platform RAM/IO: read data appears one cycle after its address, frozen with rdy.
    always @(posedge clk) begin
        if (rdy) begin
            if (mem_wr) ram[int'(mem_a)] = mem_dout;
            mem_din <= env_rd(mem_a);
        end
    end

    // Response monitor: every ready pulse pops one expected response.
    always @(negedge clk) begin
        if (ready_line) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL line_resp: unexpected ready, line=%h", line_out);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (line_out !== e) begin
                    n_err++;
                    $display("FAIL line_resp: got %h expected %h", line_out, e);
                end
            end
        end
        if (ready_io) begin
            n_vec++;
            if (exp_io_q.size() == 0) begin
                n_err++;
                $display("FAIL io_resp: unexpected ready, byte=%h", byte_out);
            end else begin
                logic [7:0] e;
                e = exp_io_q.pop_front();
                if (byte_out !== e) begin
                    n_err++;
                    $display("FAIL io_resp: got %h expected %h", byte_out, e);
                end
            end
        end
        if (ready_line || ready_io) begin
            n_vec++;
            if (prev_any) begin
                n_err++;
                $display("FAIL ready_pulse: ready high in two consecutive cycles (line=%b io=%b)", ready_line, ready_io);
            end
        end
        prev_any = ready_line || ready_io;
    end

    task automatic check_eq(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // kind: 0 line read, 1 line write, 2 IO read, 3 IO write.
    // mode: 0 issue next cycle; 1 issue now, inside the previous ready cycle;
    //       2 issue now with the controller free to accept at this edge.
    // frz: if nonzero, rdy is low for 3 cycles starting at that transfer cycle.
    task automatic do_op(input int kind, input logic [AW-1:0] addr, input logic [W-1:0] line,
                         input logic [7:0] b, input int stall, input int mode, input int frz);
        logic [AW-1:0] ea[$];
        logic          ew[$];
        logic [7:0]    ed[$];
        logic          er[$];
        logic [AW-1:0] base;
        logic [W-1:0]  el;
        int            off, fi, bad, n;
        logic          own, other;
        string         msg;
        base = addr & ~AW'(LB - 1);
        off  = (mode == 1) ? 1 : 0;
        bad  = 0;
        msg  = "";
        if (off == 1) begin
            ea.push_back('0); ew.push_back(1'b0); ed.push_back('0); er.push_back(1'b0);
        end
        case (kind)
            0: begin
                for (int k = 0; k < LB; k++) begin
                    ea.push_back(base + AW'(k)); ew.push_back(1'b0); ed.push_back('0); er.push_back(1'b0);
                    el[8*k +: 8] = ref_rd(base + AW'(k));
                end
                ea.push_back('0); ew.push_back(1'b0); ed.push_back('0); er.push_back(1'b0);
                ea.push_back('0); ew.push_back(1'b0); ed.push_back('0); er.push_back(1'b1);
                last_line = el;
                exp_q.push_back(el);
            end
            1: begin
                for (int k = 0; k < LB; k++) begin
                    ea.push_back(base + AW'(k)); ew.push_back(1'b1); ed.push_back(line[8*k +: 8]); er.push_back(1'b0);
                    ref_mem[int'(base + AW'(k))] = line[8*k +: 8];
                end
                ea.push_back('0); ew.push_back(1'b0); ed.push_back('0); er.push_back(1'b1);
                exp_q.push_back(last_line);
            end
            2: begin
                ea.push_back(addr); ew.push_back(1'b0); ed.push_back('0); er.push_back(1'b0);
                ea.push_back('0);   ew.push_back(1'b0); ed.push_back('0); er.push_back(1'b0);
                ea.push_back('0);   ew.push_back(1'b0); ed.push_back('0); er.push_back(1'b1);
                last_byte = ref_rd(addr);
                exp_io_q.push_back(last_byte);
            end
            default: begin
                for (int k = 0; k < stall; k++) begin
                    ea.push_back('0); ew.push_back(1'b0); ed.push_back('0); er.push_back(1'b0);
                end
                ea.push_back(addr); ew.push_back(1'b1); ed.push_back(b);   er.push_back(1'b0);
                ea.push_back('0);   ew.push_back(1'b0); ed.push_back('0); er.push_back(1'b1);
                ref_mem[int'(addr)] = b;
                exp_io_q.push_back(last_byte);
            end
        endcase
        // A frozen cycle repeats with writes gated; the cycle after the freeze repeats it again.
        fi = off + frz - 1;
        if (frz > 0) begin
            for (int r = 0; r < 3; r++) begin
                ea.insert(fi, ea[fi]); ed.insert(fi, ed[fi]); er.insert(fi, er[fi]); ew.insert(fi, 1'b0);
            end
        end
        n = ea.size();

        if (mode == 0) begin
            valid_line = 1'b0;
            valid_io   = 1'b0;
            @(posedge clk);
            #1;
        end
        rdy = 1'b1;
        if (kind < 2) begin
            valid_io = 1'b0; valid_line = 1'b1; rw_line = (kind == 1); addr_line = addr; line_in = line;
        end else begin
            valid_line = 1'b0; valid_io = 1'b1; rw_io = (kind == 3); addr_io = addr; byte_in = b;
        end
        io_buffer_full = (kind == 3) && (stall > 0);

        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            rdy = !((frz > 0) && (k >= fi) && (k < fi + 3));
            io_buffer_full = (kind == 3) && (k < off + stall);
            #1;
            own   = (kind < 2) ? ready_line : ready_io;
            other = (kind < 2) ? ready_io : ready_line;
            if (mem_a !== ea[k] || mem_wr !== ew[k] || (ew[k] && mem_dout !== ed[k]) || own !== er[k] || other !== 1'b0) begin
                if (bad == 0)
                    msg = $sformatf("cycle %0d: mem_a=%h wr=%b dout=%h ready=%b other=%b, expected mem_a=%h wr=%b dout=%h ready=%b other=0",
                                    k + 1, mem_a, mem_wr, mem_dout, own, other, ea[k], ew[k], ed[k], er[k]);
                bad++;
            end
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL trace kind=%0d addr=%h: %0d bad cycles, first at %s", kind, addr, bad, msg);
        end
        io_buffer_full = 1'b0;
    endtask

    initial begin
        logic [W-1:0]  line;
        logic [AW-1:0] a;
        int            bad;
        rst = 1'b1; rdy = 1'b1;
        valid_line = 1'b0; rw_line = 1'b0; addr_line = '0; line_in = '0;
        valid_io = 1'b0; rw_io = 1'b0; addr_io = '0; byte_in = '0;
        io_buffer_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_mem_a", W'(mem_a), '0);
        check_eq("reset_mem_wr", W'(mem_wr), '0);
        check_eq("reset_mem_dout", W'(mem_dout), '0);
        check_eq("reset_ready_line", W'(ready_line), '0);
        check_eq("reset_ready_io", W'(ready_io), '0);
        check_eq("reset_line_out", line_out, '0);
        check_eq("reset_byte_out", W'(byte_out), '0);
        rst = 1'b0;

        for (int i = 0; i < LB; i++) begin
            ram[32'h1230 + i]     = 8'(8'h10 + i);
            ref_mem[32'h1230 + i] = 8'(8'h10 + i);
        end
        ram[32'h30000]     = 8'h41;
        ref_mem[32'h30000] = 8'h41;

        do_op(0, 32'h0000_1234, '0, 8'h00, 0, 0, 0);
        for (int i = 0; i < LB; i++) line[8*i +: 8] = 8'(8'hA0 + i);
        do_op(1, 32'h0000_2000, line, 8'h00, 0, 0, 0);
        for (int i = 0; i < LB; i++) check_eq("ram_line_write", W'(env_rd(32'h2000 + i)), W'(8'hA0 + i));

        // Read with valid held, then a writeback presented inside the ready cycle.
        do_op(0, 32'h0000_2808, '0, 8'h00, 0, 0, 0);
        for (int i = 0; i < LB; i++) line[8*i +: 8] = 8'($urandom);
        do_op(1, 32'h0000_3000, line, 8'h00, 0, 1, 0);

        do_op(2, 32'h0003_0000, '0, 8'h00, 0, 0, 0);
        do_op(3, 32'h0003_0000, '0, 8'h5A, 5, 0, 0);
        check_eq("ram_io_write", W'(env_rd(32'h30000)), W'(8'h5A));
        do_op(2, 32'h0003_0000, '0, 8'h00, 0, 0, 0);
        do_op(0, 32'hFFFF_FFF7, '0, 8'h00, 0, 0, 0);
        do_op(0, 32'h0000_3004, '0, 8'h00, 0, 0, 5);
        for (int i = 0; i < LB; i++) line[8*i +: 8] = 8'($urandom);
        do_op(1, 32'h0000_4010, line, 8'h00, 0, 0, 4);

        // Both ports request together; reset lands in cycle 8 of the line read.
        valid_line = 1'b0; valid_io = 1'b0;
        @(posedge clk);
        #1;
        valid_line = 1'b1; rw_line = 1'b0; addr_line = 32'h0000_4440;
        valid_io   = 1'b1; rw_io   = 1'b0; addr_io   = 32'h0003_0000;
        bad = 0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #2;
            if (mem_a !== 32'h4440 + k - 1 || mem_wr !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL line_priority: %0d of 7 cycles off the line-read address walk, last mem_a=%h", bad, mem_a);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        valid_line = 1'b0;
        #1;
        check_eq("abort_mem_a", W'(mem_a), '0);
        check_eq("abort_mem_wr", W'(mem_wr), '0);
        check_eq("abort_mem_dout", W'(mem_dout), '0);
        check_eq("abort_ready_line", W'(ready_line), '0);
        check_eq("abort_ready_io", W'(ready_io), '0);
        check_eq("abort_line_out", line_out, '0);
        check_eq("abort_byte_out", W'(byte_out), '0);
        last_line = '0;
        last_byte = '0;
        do_op(2, 32'h0003_0000, '0, 8'h00, 0, 2, 0);

        for (int t = 0; t < 40; t++) begin
            int kind, mode, frz;
            kind = $urandom_range(0, 3);
            mode = ($urandom_range(0, 4) == 0) ? 1 : 0;
            frz  = (kind < 2 && $urandom_range(0, 3) == 0) ? $urandom_range(2, 10) : 0;
            for (int i = 0; i < LB; i++) line[8*i +: 8] = 8'($urandom);
            if (kind < 2) a = AW'($urandom_range(0, 1023));
            else          a = AW'(32'h100 + $urandom_range(0, 63));
            do_op(kind, a, line, 8'($urandom), $urandom_range(0, 3), mode, frz);
        end

        valid_line = 1'b0; valid_io = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("line_queue_drained", W'(exp_q.size()), '0);
        check_eq("io_queue_drained", W'(exp_io_q.size()), '0);
        foreach (ref_mem[k]) check_eq($sformatf("ram[%h]", k), W'(env_rd(AW'(k))), W'(ref_mem[k]));
        foreach (ram[k]) check_eq($sformatf("ram_extra[%h]", k), W'(ram[k]), W'(ref_rd(AW'(k))));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
